// File: rtl/alu_div_seq.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU with a fixed WIDTH+2 cycle latency.
// Operands are latched on start; signs are applied and special cases resolved in a single FIX cycle.
module alu_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic             div0_o
);

  localparam int unsigned CNT_W = 6;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic             w_latch;
  logic             w_iter;
  logic             w_fix;
  logic             w_busy_nxt;
  logic             w_done_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_div0;
  logic             r_ovf;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_iter      = 1'b0;
    w_fix       = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_latch     = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_iter = 1'b1;
        if (r_cnt == LAST_ITER) begin
          w_state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (start_i) begin
          w_latch     = 1'b1;
          w_state_nxt = S_CALC;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt == S_CALC) || (w_state_nxt == S_FIX);
    w_done_nxt = (w_state_nxt == S_DONE);
  end

  // Operand conditioning, one restoring step, and sign/special-case fixup
  always_comb begin
    w_a_neg = signed_i & a_i[WIDTH-1];
    w_b_neg = signed_i & b_i[WIDTH-1];
    w_a_mag = w_a_neg ? (~a_i + WIDTH'(1)) : a_i;
    w_b_mag = w_b_neg ? (~b_i + WIDTH'(1)) : b_i;
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_div};
    w_q_fix = r_q_neg ? (~r_quo + WIDTH'(1)) : r_quo;
    w_r_fix = r_r_neg ? (~r_rem + WIDTH'(1)) : r_rem;
    if (r_div0) begin
      w_q_fix = '1;
      w_r_fix = r_a_raw;
    end else if (r_ovf) begin
      w_q_fix = MIN_NEG;
      w_r_fix = '0;
    end
  end

  // Datapath and registered outputs; r_quo holds the dividend and fills with quotient bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_a_raw <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
      r_div0  <= 1'b0;
      r_ovf   <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      q_o     <= '0;
      r_o     <= '0;
      div0_o  <= 1'b0;
    end else begin
      busy_o <= w_busy_nxt;
      done_o <= w_done_nxt;
      if (w_latch) begin
        r_cnt   <= '0;
        r_a_raw <= a_i;
        r_div   <= w_b_mag;
        r_rem   <= '0;
        r_quo   <= w_a_mag;
        r_q_neg <= w_a_neg ^ w_b_neg;
        r_r_neg <= w_a_neg;
        r_div0  <= (b_i == '0);
        r_ovf   <= signed_i && (a_i == MIN_NEG) && (b_i == '1);
      end else if (w_iter) begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
        r_rem <= w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
      end
      if (w_fix) begin
        q_o    <= w_q_fix;
        r_o    <= w_r_fix;
        div0_o <= r_div0;
      end
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed self-checking bench for alu_div_seq: results, latency, busy/done protocol and reset.
module tb_alu_div_seq;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic        signed_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] q_o;
  logic [31:0] r_o;
  logic        div0_o;

  int n_pass;
  int n_total;

  alu_div_seq #(.WIDTH(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .signed_i (signed_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .q_o      (q_o),
    .r_o      (r_o),
    .div0_o   (div0_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Launches one division from a negedge; k counts negedges after the sampling posedge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int pulse_k, input logic [31:0] pa, input logic [31:0] pb,
                        input bit stop_at_done,
                        output int lat, output int busy_n, output int done_n,
                        output logic [31:0] q, output logic [31:0] r, output logic d0,
                        output logic [31:0] q_mid);
    lat = 0; busy_n = 0; done_n = 0; q = '0; r = '0; d0 = 1'b0; q_mid = '0;
    a_i = a; b_i = b; signed_i = s; start_i = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_i);
      if (k == 1) start_i = 1'b0;
      if (k == pulse_k) begin
        q_mid = q_o;
        a_i = pa; b_i = pb; signed_i = ~s; start_i = 1'b1;
      end
      if (k == pulse_k + 1) start_i = 1'b0;
      if (busy_o) busy_n++;
      if (done_o) begin
        done_n++;
        if (lat == 0) begin
          lat = k; q = q_o; r = r_o; d0 = div0_o;
        end
        if (stop_at_done) break;
      end
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1; start_i = 1'b1; a_i = 32'd5; b_i = 32'd1; signed_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset busy: got %b exp 0", busy_o); else n_pass++;
    n_total++; if (done_o !== 1'b0) $display("FAIL reset done: got %b exp 0", done_o); else n_pass++;
    n_total++; if (q_o !== 32'h0) $display("FAIL reset q: got %h exp 0", q_o); else n_pass++;
    n_total++; if (r_o !== 32'h0) $display("FAIL reset r: got %h exp 0", r_o); else n_pass++;
    n_total++; if (div0_o !== 1'b0) $display("FAIL reset div0: got %b exp 0", div0_o); else n_pass++;
    rst_i = 1'b0; start_i = 1'b0;
    @(negedge clk_i);
    n_total++; if (busy_o !== 1'b0) $display("FAIL reset idle busy: got %b exp 0", busy_o); else n_pass++;
  endtask

  task automatic test_unsigned;
    int lat, bn, dn; logic [31:0] q, r, qm; logic d0;
    run_op(32'd100, 32'd7, 1'b0, 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (lat !== 34) $display("FAIL u100_7 latency: got %0d exp 34", lat); else n_pass++;
    n_total++; if (bn !== 33) $display("FAIL u100_7 busy cycles: got %0d exp 33", bn); else n_pass++;
    n_total++; if (dn !== 1) $display("FAIL u100_7 done pulses: got %0d exp 1", dn); else n_pass++;
    n_total++; if (q !== 32'd14) $display("FAIL u100_7 q: got %h exp %h", q, 32'd14); else n_pass++;
    n_total++; if (r !== 32'd2) $display("FAIL u100_7 r: got %h exp %h", r, 32'd2); else n_pass++;
    n_total++; if (d0 !== 1'b0) $display("FAIL u100_7 div0: got %b exp 0", d0); else n_pass++;
    run_op(32'hFFFFFFFF, 32'h10, 1'b0, 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (q !== 32'h0FFFFFFF) $display("FAIL uffff_16 q: got %h exp 0fffffff", q); else n_pass++;
    n_total++; if (r !== 32'hF) $display("FAIL uffff_16 r: got %h exp 0000000f", r); else n_pass++;
  endtask

  task automatic test_signed;
    int lat, bn, dn; logic [31:0] q, r, qm; logic d0;
    run_op(32'hFFFFFFF9, 32'd2, 1'b1, 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (lat !== 34) $display("FAIL s-7_2 latency: got %0d exp 34", lat); else n_pass++;
    n_total++; if (q !== 32'hFFFFFFFD) $display("FAIL s-7_2 q: got %h exp fffffffd", q); else n_pass++;
    n_total++; if (r !== 32'hFFFFFFFF) $display("FAIL s-7_2 r: got %h exp ffffffff", r); else n_pass++;
    run_op(32'd100, 32'hFFFFFFF9, 1'b1, 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (q !== 32'hFFFFFFF2) $display("FAIL s100_-7 q: got %h exp fffffff2", q); else n_pass++;
    n_total++; if (r !== 32'd2) $display("FAIL s100_-7 r: got %h exp 00000002", r); else n_pass++;
    run_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (q !== 32'd14) $display("FAIL s-100_-7 q: got %h exp 0000000e", q); else n_pass++;
    n_total++; if (r !== 32'hFFFFFFFE) $display("FAIL s-100_-7 r: got %h exp fffffffe", r); else n_pass++;
  endtask

  task automatic test_div0;
    int lat, bn, dn; logic [31:0] q, r, qm; logic d0;
    for (int m = 0; m < 2; m++) begin
      run_op(32'h12345678, 32'h0, 1'(m), 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
      n_total++; if (lat !== 34) $display("FAIL div0 mode%0d latency: got %0d exp 34", m, lat); else n_pass++;
      n_total++; if (q !== 32'hFFFFFFFF) $display("FAIL div0 mode%0d q: got %h exp ffffffff", m, q); else n_pass++;
      n_total++; if (r !== 32'h12345678) $display("FAIL div0 mode%0d r: got %h exp 12345678", m, r); else n_pass++;
      n_total++; if (d0 !== 1'b1) $display("FAIL div0 mode%0d div0: got %b exp 1", m, d0); else n_pass++;
    end
    run_op(32'h80000001, 32'h0, 1'b1, 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (q !== 32'hFFFFFFFF) $display("FAIL div0 neg q: got %h exp ffffffff", q); else n_pass++;
    n_total++; if (r !== 32'h80000001) $display("FAIL div0 neg r: got %h exp 80000001", r); else n_pass++;
  endtask

  task automatic test_overflow;
    int lat, bn, dn; logic [31:0] q, r, qm; logic d0;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (lat !== 34) $display("FAIL ovf signed latency: got %0d exp 34", lat); else n_pass++;
    n_total++; if (q !== 32'h80000000) $display("FAIL ovf signed q: got %h exp 80000000", q); else n_pass++;
    n_total++; if (r !== 32'h0) $display("FAIL ovf signed r: got %h exp 00000000", r); else n_pass++;
    n_total++; if (d0 !== 1'b0) $display("FAIL ovf signed div0: got %b exp 0", d0); else n_pass++;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (q !== 32'h0) $display("FAIL ovf unsigned q: got %h exp 00000000", q); else n_pass++;
    n_total++; if (r !== 32'h80000000) $display("FAIL ovf unsigned r: got %h exp 80000000", r); else n_pass++;
  endtask

  task automatic test_ignore_start;
    int lat, bn, dn; logic [31:0] q, r, qm; logic d0;
    run_op(32'd77, 32'd7, 1'b0, 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (q !== 32'd11) $display("FAIL ign pre q: got %h exp 0000000b", q); else n_pass++;
    run_op(32'd1000, 32'd10, 1'b0, 10, 32'd5, 32'd5, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (qm !== 32'd11) $display("FAIL ign q held in calc: got %h exp 0000000b", qm); else n_pass++;
    n_total++; if (lat !== 34) $display("FAIL ign latency: got %0d exp 34", lat); else n_pass++;
    n_total++; if (dn !== 1) $display("FAIL ign done pulses: got %0d exp 1", dn); else n_pass++;
    n_total++; if (q !== 32'd100) $display("FAIL ign q: got %h exp 00000064", q); else n_pass++;
    n_total++; if (r !== 32'd0) $display("FAIL ign r: got %h exp 00000000", r); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat, bn, dn; logic [31:0] q, r, qm; logic d0;
    run_op(32'd50, 32'd3, 1'b0, 0, 32'h0, 32'h0, 1'b1, lat, bn, dn, q, r, d0, qm);
    n_total++; if (lat !== 34) $display("FAIL b2b first latency: got %0d exp 34", lat); else n_pass++;
    n_total++; if (q !== 32'd16) $display("FAIL b2b first q: got %h exp 00000010", q); else n_pass++;
    n_total++; if (r !== 32'd2) $display("FAIL b2b first r: got %h exp 00000002", r); else n_pass++;
    run_op(32'hFFFFFFCE, 32'd3, 1'b1, 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (lat !== 34) $display("FAIL b2b second latency: got %0d exp 34", lat); else n_pass++;
    n_total++; if (dn !== 1) $display("FAIL b2b second done pulses: got %0d exp 1", dn); else n_pass++;
    n_total++; if (bn !== 33) $display("FAIL b2b second busy cycles: got %0d exp 33", bn); else n_pass++;
    n_total++; if (q !== 32'hFFFFFFF0) $display("FAIL b2b second q: got %h exp fffffff0", q); else n_pass++;
    n_total++; if (r !== 32'hFFFFFFFE) $display("FAIL b2b second r: got %h exp fffffffe", r); else n_pass++;
  endtask

  task automatic test_reset_midop;
    int lat, bn, dn, stray; logic [31:0] q, r, qm; logic d0;
    a_i = 32'd1000; b_i = 32'd0; signed_i = 1'b1; start_i = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk_i);
      if (k == 1) start_i = 1'b0;
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    n_total++; if (busy_o !== 1'b0) $display("FAIL midrst busy: got %b exp 0", busy_o); else n_pass++;
    n_total++; if (done_o !== 1'b0) $display("FAIL midrst done: got %b exp 0", done_o); else n_pass++;
    n_total++; if (q_o !== 32'h0) $display("FAIL midrst q: got %h exp 00000000", q_o); else n_pass++;
    n_total++; if (r_o !== 32'h0) $display("FAIL midrst r: got %h exp 00000000", r_o); else n_pass++;
    n_total++; if (div0_o !== 1'b0) $display("FAIL midrst div0: got %b exp 0", div0_o); else n_pass++;
    rst_i = 1'b0;
    stray = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk_i);
      if (done_o || busy_o) stray++;
    end
    n_total++; if (stray !== 0) $display("FAIL midrst aborted activity: got %0d exp 0", stray); else n_pass++;
    run_op(32'hFFFFFFFF, 32'd1, 1'b0, 0, 32'h0, 32'h0, 1'b0, lat, bn, dn, q, r, d0, qm);
    n_total++; if (lat !== 34) $display("FAIL post-rst latency: got %0d exp 34", lat); else n_pass++;
    n_total++; if (q !== 32'hFFFFFFFF) $display("FAIL post-rst q: got %h exp ffffffff", q); else n_pass++;
    n_total++; if (r !== 32'h0) $display("FAIL post-rst r: got %h exp 00000000", r); else n_pass++;
    n_total++; if (d0 !== 1'b0) $display("FAIL post-rst div0: got %b exp 0", d0); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    rst_i = 1'b1; start_i = 1'b0; signed_i = 1'b0; a_i = '0; b_i = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div0();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_div_seq.md
ALU_DIV_SEQ -- requirements
Module: alu_div_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; only 32 is verified.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, the reset: synchronous, active-high.
REQ-004 The block SHALL have port start_i, input, 1, the request to begin a division with the current a_i, b_i and signed_i.
REQ-005 The block SHALL have port signed_i, input, 1: 1 selects signed (DIV/REM), 0 selects unsigned (DIVU/REMU).
REQ-006 The block SHALL have port a_i, input, WIDTH, the dividend.
REQ-007 The block SHALL have port b_i, input, WIDTH, the divisor.
REQ-008 The block SHALL have port busy_o, output, 1, high while a division is in progress.
REQ-009 The block SHALL have port done_o, output, 1, a one-cycle pulse marking q_o/r_o valid.
REQ-010 The block SHALL have port q_o, output, WIDTH, the quotient.
REQ-011 The block SHALL have port r_o, output, WIDTH, the remainder.
REQ-012 The block SHALL have port div0_o, output, 1, high with done_o when b_i was zero.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-014 IDLE or DONE with start_i=1 SHALL latch a_i, b_i and signed_i, clear the iteration counter, and go to CALC.
REQ-015 start_i SHALL be ignored in CALC and FIX; latched operands SHALL NOT change mid-operation.
REQ-016 Signed mode SHALL convert negative operands to magnitudes by two's-complement negation at latch time, and record quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a).
REQ-017 CALC SHALL run exactly WIDTH iterations of restoring division, one per cycle: shift the partial remainder left by one bit, bringing in the next dividend bit MSB-first; compute trial = partial - divisor as a WIDTH+1-bit subtraction; if trial is non-negative, keep trial and set the quotient bit to 1, else keep the partial and set the bit to 0.
REQ-018 A 6-bit counter SHALL count the iterations; after iteration WIDTH-1 the FSM SHALL go to FIX.
REQ-019 FIX SHALL apply the recorded signs (negate the quotient and/or remainder), apply the special cases, register q_o/r_o/div0_o, and go to DONE.
REQ-020 DONE SHALL assert done_o for exactly one cycle, then go to IDLE, unless start_i=1 per REQ-014.
REQ-021 Latency SHALL be fixed: done_o is high in cycle N+WIDTH+2, where N is the cycle start_i is sampled high (34 cycles for WIDTH=32), including the special cases.
REQ-022 busy_o SHALL be high in CALC and FIX and low in IDLE and DONE.
REQ-023 Divide by zero SHALL give q_o = all ones, r_o = dividend (as given, unsigned or signed), div0_o=1.
REQ-024 Signed overflow (a = 0x80000000, b = 0xFFFFFFFF) SHALL give q_o = 0x80000000, r_o = 0, div0_o=0.
REQ-025 q_o, r_o and div0_o SHALL hold their last values until the next FIX; they SHALL NOT change during CALC.
REQ-026 A new start_i accepted in the DONE cycle SHALL be back-to-back legal, with no lost or duplicated done_o.

Reset
REQ-027 With rst_i=1 at a clock edge, the FSM SHALL go to IDLE, the counter and internal registers SHALL clear, and busy_o=0, done_o=0, q_o=0, r_o=0, div0_o=0.
REQ-028 Reset SHALL take priority over start_i; reset mid-CALC or mid-FIX SHALL abort with no done_o pulse.
REQ-029 After reset deasserts, the first start_i SHALL behave per REQ-014 with no extra delay.

Verification
REQ-030 Unsigned: a=100, b=7, signed_i=0 -> done_o exactly 34 cycles later; q_o=14, r_o=2, div0_o=0; busy_o high for 33 cycles.
REQ-031 Signed: a=-7 (0xFFFFFFF9), b=2, signed_i=1 -> q_o=0xFFFFFFFD (-3), r_o=0xFFFFFFFF (-1).
REQ-032 Divide by zero: a=0x12345678, b=0, either mode -> q_o=0xFFFFFFFF, r_o=0x12345678, div0_o=1, same latency.
REQ-033 Overflow: a=0x80000000, b=0xFFFFFFFF, signed_i=1 -> q_o=0x80000000, r_o=0; with signed_i=0 -> q_o=0, r_o=0x80000000.
REQ-034 Protocol: start_i pulsed again at cycle N+10 with different operands -> ignored, result is from the first operands; start_i in the DONE cycle -> second done_o 34 cycles later.
REQ-035 Reset mid-op: rst_i at cycle N+15 -> all outputs 0 next cycle, no done_o; a subsequent 0xFFFFFFFF/1 unsigned -> q_o=0xFFFFFFFF, r_o=0.
